// File: rtl/fpu_dispatch_pkg.sv
// Shared types for the core-side FPU command dispatcher.
package fpu_dispatch_pkg;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] data;
  } fpu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dispatch_state_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous FIFO of FPU commands; DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module fpu_cmd_fifo
  import fpu_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  fpu_cmd_t               wr_cmd,
  output fpu_cmd_t               rd_cmd,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fpu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == DEPTH[AW:0]);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_cmd  = mem[rd_ptr];

  // Storage needs no reset: a flushed queue is defined by its pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_cmd;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_dispatch.sv
// Core-side initiator: queues FPU commands, issues them one at a time,
// waits for fpu_valid or a timeout, and hands the result back to the core.
module fpu_dispatch
  import fpu_dispatch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [4:0]  req_x1,
  input  logic [4:0]  req_x2,
  input  logic [4:0]  req_y,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_cond,
  output logic        resp_timeout,
  output logic        fpu_ready,
  output logic [5:0]  fpu_operation,
  output logic [4:0]  fpu_x1,
  output logic [4:0]  fpu_x2,
  output logic [4:0]  fpu_y,
  output logic [31:0] fpu_in_data,
  input  logic        fpu_valid,
  input  logic [31:0] fpu_out_data,
  input  logic        fpu_cond,
  output logic        busy
);

  localparam int            TW         = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  dispatch_state_t         state;
  dispatch_state_t         state_next;
  fpu_cmd_t                issue_q;
  fpu_cmd_t                fifo_head;
  fpu_cmd_t                req_cmd;
  logic [TW-1:0]           timer;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    load_issue;
  logic                    take_result;
  logic                    take_timeout;
  logic                    timer_inc;

  assign req_cmd   = '{op: req_op, x1: req_x1, x2: req_x2, y: req_y, data: req_data};
  assign req_ready = !fifo_full;

  fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push   (req_valid && req_ready),
    .pop    (load_issue),
    .wr_cmd (req_cmd),
    .rd_cmd (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // A valid arriving in the final timeout cycle takes priority over the abort.
  always_comb begin
    state_next   = state;
    load_issue   = 1'b0;
    take_result  = 1'b0;
    take_timeout = 1'b0;
    timer_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load_issue = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (fpu_valid) begin
          take_result = 1'b1;
          state_next  = RESP;
        end else if (timer == TIMER_LAST) begin
          take_timeout = 1'b1;
          state_next   = RESP;
        end else begin
          timer_inc = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_q      <= '0;
      timer        <= '0;
      resp_data    <= '0;
      resp_cond    <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      if (load_issue) begin
        issue_q <= fifo_head;
        timer   <= '0;
      end else if (timer_inc) begin
        timer <= timer + 1'b1;
      end
      if (take_result) begin
        resp_data    <= fpu_out_data;
        resp_cond    <= fpu_cond;
        resp_timeout <= 1'b0;
      end else if (take_timeout) begin
        resp_data    <= '0;
        resp_cond    <= 1'b0;
        resp_timeout <= 1'b1;
      end
    end
  end

  assign fpu_ready     = (state == BUSY);
  assign resp_valid    = (state == RESP);
  assign fpu_operation = issue_q.op;
  assign fpu_x1        = issue_q.x1;
  assign fpu_x2        = issue_q.x2;
  assign fpu_y         = issue_q.y;
  assign fpu_in_data   = issue_q.data;
  assign busy          = (fifo_count != '0) || (state != IDLE);

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: directed scenarios plus randomized
// traffic compared every cycle against a queue-based behavioural model.
module tb_fpu_dispatch;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [4:0]  req_x1, req_x2, req_y;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_cond;
  logic        resp_timeout;
  logic        fpu_ready;
  logic [5:0]  fpu_operation;
  logic [4:0]  fpu_x1, fpu_x2, fpu_y;
  logic [31:0] fpu_in_data;
  logic        fpu_valid;
  logic [31:0] fpu_out_data;
  logic        fpu_cond;
  logic        busy;

  fpu_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_x1        (req_x1),
    .req_x2        (req_x2),
    .req_y         (req_y),
    .req_data      (req_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_cond     (resp_cond),
    .resp_timeout  (resp_timeout),
    .fpu_ready     (fpu_ready),
    .fpu_operation (fpu_operation),
    .fpu_x1        (fpu_x1),
    .fpu_x2        (fpu_x2),
    .fpu_y         (fpu_y),
    .fpu_in_data   (fpu_in_data),
    .fpu_valid     (fpu_valid),
    .fpu_out_data  (fpu_out_data),
    .fpu_cond      (fpu_cond),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] data;
  } cmd_s;

  // Model: pending commands, the one outstanding op, and the held response.
  cmd_s        mq[$];
  cmd_s        m_cmd;
  bit          m_ready;
  bit          m_resp;
  logic [31:0] m_rdata;
  bit          m_rcond;
  bit          m_rto;
  int          m_age;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int low_run;
  int hi_cnt;

  function automatic void modelReset();
    mq.delete();
    m_cmd   = '0;
    m_ready = 0;
    m_resp  = 0;
    m_rdata = '0;
    m_rcond = 0;
    m_rto   = 0;
    m_age   = 0;
    low_run = 2;
  endfunction

  function automatic void modelStep();
    bit   can_push;
    cmd_s c;
    can_push = req_valid && (mq.size() < DEPTH);
    if (!m_ready && !m_resp) begin
      if (mq.size() > 0) begin
        m_cmd   = mq.pop_front();
        m_ready = 1;
        m_age   = 0;
      end
    end else if (m_ready) begin
      m_age++;
      if (fpu_valid) begin
        m_rdata = fpu_out_data;
        m_rcond = fpu_cond;
        m_rto   = 0;
        m_ready = 0;
        m_resp  = 1;
      end else if (m_age == TIMEOUT) begin
        m_rdata = '0;
        m_rcond = 0;
        m_rto   = 1;
        m_ready = 0;
        m_resp  = 1;
      end
    end else if (resp_ready) begin
      m_resp = 0;
    end
    if (can_push) begin
      c = '{op: req_op, x1: req_x1, x2: req_x2, y: req_y, data: req_data};
      mq.push_back(c);
    end
  endfunction

  task automatic compareVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Compare every observable output against the model, plus the low-gap rule.
  task automatic checkOutput();
    compareVal("req_ready", req_ready, mq.size() < DEPTH);
    compareVal("busy", busy, (mq.size() > 0) || m_ready || m_resp);
    compareVal("fpu_ready", fpu_ready, m_ready);
    compareVal("fpu_operation", fpu_operation, m_cmd.op);
    compareVal("fpu_x1", fpu_x1, m_cmd.x1);
    compareVal("fpu_x2", fpu_x2, m_cmd.x2);
    compareVal("fpu_y", fpu_y, m_cmd.y);
    compareVal("fpu_in_data", fpu_in_data, m_cmd.data);
    compareVal("resp_valid", resp_valid, m_resp);
    compareVal("resp_data", resp_data, m_rdata);
    compareVal("resp_cond", resp_cond, m_rcond);
    compareVal("resp_timeout", resp_timeout, m_rto);
    if (fpu_ready) begin
      if (low_run > 0) compareVal("ready_low_gap_ge2", low_run >= 2, 1);
      low_run = 0;
    end else begin
      low_run++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input bit slow_fpu);
    req_valid    = ($urandom_range(0, 2) != 0);
    req_op       = 6'($urandom());
    req_x1       = 5'($urandom());
    req_x2       = 5'($urandom());
    req_y        = 5'($urandom());
    req_data     = $urandom();
    resp_ready   = ($urandom_range(0, 3) != 0);
    fpu_valid    = slow_fpu ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
    fpu_out_data = $urandom();
    fpu_cond     = 1'($urandom());
  endtask

  task automatic pushCmd(input logic [5:0] op, input logic [4:0] y, input logic [31:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_x1    = 5'd2;
    req_x2    = 5'd3;
    req_y     = y;
    req_data  = d;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 0; req_op = 0; req_x1 = 0; req_x2 = 0; req_y = 0; req_data = 0;
    resp_ready = 0; fpu_valid = 0; fpu_out_data = 0; fpu_cond = 0;
    modelReset();
    #3;
    compareVal("rst_req_ready", req_ready, 1);
    compareVal("rst_busy", busy, 0);
    compareVal("rst_fpu_ready", fpu_ready, 0);
    compareVal("rst_resp_valid", resp_valid, 0);
    compareVal("rst_fpu_in_data", fpu_in_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    checkOutput();

    // OPSET with a 3-cycle fpu latency.
    pushCmd(6'h01, 5'd1, 32'h3f800000);
    tick();
    compareVal("opset_ready", fpu_ready, 1);
    compareVal("opset_in_data", fpu_in_data, 32'h3f800000);
    compareVal("opset_y", fpu_y, 5'd1);
    tick();
    tick();
    compareVal("opset_in_data_held", fpu_in_data, 32'h3f800000);
    fpu_valid = 1; fpu_out_data = 32'h12345678; fpu_cond = 1;
    tick();
    fpu_valid = 0;
    compareVal("opset_resp_valid", resp_valid, 1);
    compareVal("opset_resp_data", resp_data, 32'h12345678);
    compareVal("opset_resp_to", resp_timeout, 0);
    compareVal("opset_ready_drop", fpu_ready, 0);
    resp_ready = 1;
    tick();
    compareVal("opset_resp_done", resp_valid, 0);
    resp_ready = 0;

    // Silent fpu: abort after exactly TIMEOUT cycles of fpu_ready.
    pushCmd(6'h05, 5'd4, 32'hcafef00d);
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fpu_ready) hi_cnt++;
      if (resp_valid) break;
    end
    compareVal("timeout_ready_cycles", hi_cnt, 16);
    compareVal("timeout_flag", resp_timeout, 1);
    compareVal("timeout_data", resp_data, 0);
    fpu_valid = 1; fpu_out_data = 32'hdeadbeef; fpu_cond = 1;
    tick();
    fpu_valid = 0;
    compareVal("late_valid_dropped", resp_data, 0);
    resp_ready = 1;
    tick();
    resp_ready = 0;

    // Valid in the last timeout cycle wins over the abort.
    pushCmd(6'h07, 5'd9, 32'h00c0ffee);
    tick();
    repeat (15) tick();
    compareVal("edge_still_ready", fpu_ready, 1);
    fpu_valid = 1; fpu_out_data = 32'h3fd9999a; fpu_cond = 0;
    tick();
    fpu_valid = 0;
    compareVal("edge_to_flag", resp_timeout, 0);
    compareVal("edge_data", resp_data, 32'h3fd9999a);
    resp_ready = 1;
    tick();

    // Randomized traffic, alternating fast and stalling fpu behaviour.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(((i / 250) % 2) == 1);
      tick();
    end

    // Drain, then reset while BUSY with three commands queued.
    req_valid = 0; resp_ready = 1; fpu_valid = 1;
    repeat (30) tick();
    fpu_valid = 0; resp_ready = 0;
    for (int i = 0; i < 4; i++) pushCmd(6'h09, 5'(i), 32'h1000 + i);
    compareVal("pre_rst_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    compareVal("mid_rst_fpu_ready", fpu_ready, 0);
    compareVal("mid_rst_busy", busy, 0);
    compareVal("mid_rst_req_ready", req_ready, 1);
    compareVal("mid_rst_operation", fpu_operation, 0);
    compareVal("mid_rst_in_data", fpu_in_data, 0);
    fpu_valid = 1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    modelReset();
    repeat (5) tick();
    compareVal("post_rst_no_reissue", fpu_ready, 0);
    compareVal("post_rst_resp", resp_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
